load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, maximum number of WAIT cycles without mem_ack before the unit reports an error (legal range 1..65535).
REQ-002 Port: clk  input  1  system clock; every register samples on the rising edge.
REQ-003 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 Port: req_valid  input  1  execute stage presents a load/store request.
REQ-005 Port: req_ready  output  1  unit accepts a request this cycle.
REQ-006 Port: req_load  input  1  1 = load, 0 = store.
REQ-007 Port: req_funct3  input  3  RV32I funct3 of the instruction.
REQ-008 Port: req_addr  input  32  byte address, rs1 plus Iimm or Simm.
REQ-009 Port: req_wdata  input  32  rs2 value (store data).
REQ-010 Port: resp_valid  output  1  one-cycle pulse marking completion.
REQ-011 Port: resp_rdata  output  32  formatted load data for register write-back.
REQ-012 Port: resp_err  output  1  qualifies resp_valid: misaligned access, illegal funct3, or timeout.
REQ-013 Port: mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 Port: mem_rstrb  output  1  read strobe.
REQ-015 Port: mem_wdata  output  32  lane-replicated store data.
REQ-016 Port: mem_wmask  output  4  byte write enables.
REQ-017 Port: mem_rdata  input  32  read data, valid while mem_ack is high.
REQ-018 Port: mem_ack  input  1  memory completion, a one-cycle pulse.

Function
REQ-019 The unit SHALL have four states: IDLE, ISSUE, WAIT and RESP; req_ready is 1 only in IDLE.
REQ-020 IDLE with req_valid at an edge: the unit SHALL latch load, funct3, addr and wdata, then go to RESP with error set if the request is illegal, otherwise to ISSUE.
REQ-021 Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3 values: 000 SB, 001 SH, 010 SW. Every other funct3 value SHALL be illegal.
REQ-022 A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, SHALL be illegal; an illegal request SHALL never assert mem_rstrb or mem_wmask.
REQ-023 ISSUE SHALL last exactly one cycle: a load drives mem_rstrb=1; a store drives mem_wmask as follows, then moves to WAIT.
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
REQ-024 mem_rstrb and mem_wmask SHALL be 0 in every state other than ISSUE.
REQ-025 mem_addr and mem_wdata SHALL hold their latched values from ISSUE through RESP.
REQ-026 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-027 WAIT: mem_ack sampled high SHALL move the unit to RESP with error cleared; a load SHALL capture the formatted mem_rdata at that edge.
REQ-028 Load formatting:
  - byte = lane addr[1:0]; half = lane addr[1]
  - sign-extended when funct3[2]=0, zero-extended when funct3[2]=1
  - word passed through unchanged
REQ-029 resp_rdata SHALL be 0 for stores and for every error response.
REQ-030 A 16-bit WAIT counter SHALL clear on entry to WAIT and increment each WAIT cycle without mem_ack.
REQ-031 When the counter reaches MEM_TIMEOUT without mem_ack, the unit SHALL go to RESP with error set.
REQ-032 mem_ack and mem_ack arriving on the same edge as the timeout SHALL count as success.
REQ-033 RESP SHALL assert resp_valid for exactly one cycle, with resp_rdata and resp_err valid in that cycle, then return to IDLE; resp_valid SHALL be 0 in every other state.
REQ-034 Latency, with the request accepted at edge E0:
  - an illegal request SHALL give resp_valid in the cycle after E0
  - a legal request with mem_ack sampled at edge E2 (first WAIT cycle) SHALL give resp_valid in the cycle after E2
REQ-035 mem_ack outside WAIT and req_valid outside IDLE SHALL be ignored, with no state change.

Reset
REQ-036 When resetn is low, the unit SHALL asynchronously force:
  - state to IDLE and the counter to 0
  - req_ready to 1
  - all other outputs (resp_valid, resp_err, resp_rdata, mem_addr, mem_rstrb, mem_wdata, mem_wmask) to 0
REQ-037 Reset asserted mid-transaction (ISSUE, WAIT or RESP) SHALL abandon the transaction with no resp_valid; a mem_ack arriving after reset SHALL be ignored.
REQ-038 The first request after resetn rises SHALL be accepted on the first clock edge.

Verification
REQ-039 LB at addr 0x103 with mem_rdata=0x80FF1234 acked in the first WAIT cycle -> mem_addr=0x100, mem_rstrb for one cycle, resp_rdata=0xFFFFFF80, resp_err=0, resp_valid three cycles after acceptance.
REQ-040 SH at addr 0x22, wdata=0xDEADBEEF -> mem_wmask=4'b1100 for one cycle, mem_wdata=0xBEEFBEEF, resp_rdata=0, resp_err=0.
REQ-041 LW at addr 0x06 -> no mem_rstrb, resp_valid in the next cycle with resp_err=1, resp_rdata=0; funct3=011 behaves the same.
REQ-042 LHU at 0x42 with MEM_TIMEOUT=4 and no mem_ack -> resp_err=1 exactly 4 WAIT cycles after ISSUE; a later mem_ack pulse in IDLE is ignored.
REQ-043 resetn pulsed low during WAIT -> all outputs 0 immediately, req_ready=1, no resp_valid; the next LBU at 0x01 with mem_rdata=0x0000A500 returns 0x000000A5.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decodes and checks one request, issues a single memory
// access, waits for mem_ack or a timeout, then returns formatted load data.
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | strobe memory for one cycle
//   WAIT  | waiting for mem_ack, counting towards MEM_TIMEOUT
//   RESP  | one-cycle response pulse
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_load;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata_rep;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_cnt;

  logic        w_legal;
  logic        w_timeout;
  logic [31:0] w_wdata_rep;
  logic [3:0]  w_wmask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  always_comb begin
    w_legal = 1'b0;
    if (req_load) begin
      case (req_funct3)
        3'b000, 3'b100: w_legal = 1'b1;
        3'b001, 3'b101: w_legal = ~req_addr[0];
        3'b010:         w_legal = (req_addr[1:0] == 2'b00);
        default:        w_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  w_legal = 1'b1;
        3'b001:  w_legal = ~req_addr[0];
        3'b010:  w_legal = (req_addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   w_wdata_rep = {2{req_wdata[15:0]}};
      default: w_wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_wmask = 4'b0001 << r_addr[1:0];
      2'b01:   w_wmask = 4'b0011 << r_addr[1:0];
      default: w_wmask = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] selects zero extension (LBU/LHU)
    case (r_funct3[1:0])
      2'b00:   w_load_fmt = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load_fmt = {{16{~r_funct3[2] & w_half[15]}}, w_half};
      default: w_load_fmt = mem_rdata;
    endcase
  end

  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mem_ack || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_load      <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata_rep <= 32'h0;
      r_rdata     <= 32'h0;
      r_err       <= 1'b0;
      r_cnt       <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_load      <= req_load;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata_rep <= w_wdata_rep;
            r_rdata     <= 32'h0;
            r_err       <= ~w_legal;
          end
        end
        S_ISSUE: r_cnt <= 16'h0;
        S_WAIT: begin
          // ack wins over a timeout on the same edge
          if (mem_ack) begin
            r_err <= 1'b0;
            if (r_load) r_rdata <= w_load_fmt;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_wdata_rep;
  assign mem_rstrb  = (r_state == S_ISSUE) & r_load;
  assign mem_wmask  = ((r_state == S_ISSUE) && !r_load) ? w_wmask : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner cases, and
// randomized requests checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_load = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        req_ready, resp_valid, resp_err, mem_rstrb;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ack: cycle index (1 = cycle after acceptance) in which mem_ack is high, 0 = never
  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          ack;
    int          lat;
    logic        err;
    logic [31:0] exp_rdata;
    logic [3:0]  mask;
    logic [31:0] exp_wdata;
    int          rstrb;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                              input int lat, input logic err, input logic [31:0] erd,
                              input logic [3:0] mask, input logic [31:0] ewd, input int rs);
    vec_t v;
    v.ld = ld; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ack = ack;
    v.lat = lat; v.err = err; v.exp_rdata = erd; v.mask = mask; v.exp_wdata = ewd; v.rstrb = rs;
    return v;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    int size, off;
    logic legal;
    logic [31:0] raw;
    r = v;
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    legal = v.ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 inside {3'd0, 3'd1, 3'd2});
    if ((v.addr % size) != 0) legal = 1'b0;
    off = int'(v.addr % 4);
    r.rstrb = 0; r.mask = 4'h0; r.exp_wdata = 32'h0; r.exp_rdata = 32'h0;
    if (!legal) begin
      r.lat = 1; r.err = 1'b1;
      return r;
    end
    if (v.ld) r.rstrb = 1;
    else begin
      r.mask = 4'(((1 << size) - 1) << off);
      if (size == 1)      r.exp_wdata = {24'h0, v.wdata[7:0]} * 32'h01010101;
      else if (size == 2) r.exp_wdata = {16'h0, v.wdata[15:0]} * 32'h00010001;
      else                r.exp_wdata = v.wdata;
    end
    if (v.ack >= 2 && v.ack <= T + 1) begin
      r.lat = v.ack + 1; r.err = 1'b0;
      if (v.ld) begin
        raw = v.rdata >> (8 * off);
        if (size == 1) begin
          raw = raw & 32'hFF;
          if (!v.f3[2] && raw >= 32'h80) raw = raw | 32'hFFFFFF00;
        end else if (size == 2) begin
          raw = raw & 32'hFFFF;
          if (!v.f3[2] && raw >= 32'h8000) raw = raw | 32'hFFFF0000;
        end
        r.exp_rdata = raw;
      end
    end else begin
      r.lat = T + 2; r.err = 1'b1;
    end
    return r;
  endfunction

  // Called mid-cycle; returns 1 ns after a rising edge.
  task automatic run(input vec_t v, input string tag, input bit junk);
    int n_rs, n_wm, n_rdy, lat;
    logic [3:0] om;
    logic [31:0] o_rd, o_addr, o_wd;
    logic o_err;
    bit done;
    n_rs = 0; n_wm = 0; n_rdy = 0; lat = 0; om = 4'h0; done = 1'b0;
    o_rd = 32'h0; o_addr = 32'h0; o_wd = 32'h0; o_err = 1'b0;
    req_valid = 1'b1; req_load = v.ld; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    chk({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= 40 && !done; c++) begin
      mem_ack = (c == v.ack);
      mem_rdata = (c == v.ack) ? v.rdata : $urandom();
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1)); req_load = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom(); req_wdata = $urandom();
      end else req_valid = 1'b0;
      if (mem_rstrb) n_rs++;
      if (mem_wmask != 4'h0) begin n_wm++; om = mem_wmask; end
      if (req_ready) n_rdy++;
      if (resp_valid) begin
        done = 1'b1; lat = c; o_rd = resp_rdata; o_err = resp_err; o_addr = mem_addr; o_wd = mem_wdata;
      end else begin
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0; req_valid = 1'b0;
    chk({tag, "/resp_seen"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, "/latency"}, 32'(lat), 32'(v.lat));
      chk({tag, "/resp_err"}, 32'(o_err), 32'(v.err));
      chk({tag, "/resp_rdata"}, o_rd, v.exp_rdata);
      chk({tag, "/mem_addr"}, o_addr, v.addr & 32'hFFFFFFFC);
      chk({tag, "/rstrb_cycles"}, 32'(n_rs), 32'(v.rstrb));
      chk({tag, "/wmask_cycles"}, 32'(n_wm), (v.mask != 4'h0) ? 32'd1 : 32'd0);
      chk({tag, "/wmask"}, 32'(om), 32'(v.mask));
      if (v.mask != 4'h0) chk({tag, "/mem_wdata"}, o_wd, v.exp_wdata);
      chk({tag, "/busy_ready"}, 32'(n_rdy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "/resp_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "/resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "/resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "/mem_addr"}, mem_addr, 32'h0);
    chk({tag, "/mem_rstrb"}, 32'(mem_rstrb), 32'd0);
    chk({tag, "/mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "/mem_wmask"}, 32'(mem_wmask), 32'd0);
  endtask

  initial begin
    vec_t v;
    //            ld    f3      addr          wdata         rdata         ack lat err exp_rdata     mask     exp_wdata     rs
    tbl[0]  = mk(1'b1, 3'd0, 32'h103, 32'h0,        32'h80FF1234, 2, 3, 1'b0, 32'hFFFFFF80, 4'h0,    32'h0,        1);
    tbl[1]  = mk(1'b0, 3'd1, 32'h22,  32'hDEADBEEF, 32'h0,        2, 3, 1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF, 0);
    tbl[2]  = mk(1'b1, 3'd2, 32'h06,  32'h0,        32'h11111111, 2, 1, 1'b1, 32'h0,        4'h0,    32'h0,        0);
    tbl[3]  = mk(1'b1, 3'd3, 32'h04,  32'h0,        32'h22222222, 2, 1, 1'b1, 32'h0,        4'h0,    32'h0,        0);
    tbl[4]  = mk(1'b1, 3'd5, 32'h42,  32'h0,        32'h0,        0, 6, 1'b1, 32'h0,        4'h0,    32'h0,        1);
    tbl[5]  = mk(1'b1, 3'd1, 32'h02,  32'h0,        32'h80010000, 3, 4, 1'b0, 32'hFFFF8001, 4'h0,    32'h0,        1);
    tbl[6]  = mk(1'b0, 3'd0, 32'h03,  32'h12345678, 32'h0,        5, 6, 1'b0, 32'h0,        4'b1000, 32'h78787878, 0);
    tbl[7]  = mk(1'b0, 3'd2, 32'h01,  32'h5555AAAA, 32'h0,        2, 1, 1'b1, 32'h0,        4'h0,    32'h0,        0);
    tbl[8]  = mk(1'b0, 3'd4, 32'h00,  32'h5555AAAA, 32'h0,        2, 1, 1'b1, 32'h0,        4'h0,    32'h0,        0);
    tbl[9]  = mk(1'b1, 3'd2, 32'h0C,  32'h0,        32'hCAFEF00D, 1, 6, 1'b1, 32'h0,        4'h0,    32'h0,        1);
    tbl[10] = mk(1'b1, 3'd4, 32'h02,  32'h0,        32'h00FF0000, 2, 3, 1'b0, 32'h000000FF, 4'h0,    32'h0,        1);
    tbl[11] = mk(1'b1, 3'd0, 32'h00,  32'h0,        32'h1234567F, 4, 5, 1'b0, 32'h0000007F, 4'h0,    32'h0,        1);
    tbl[12] = mk(1'b0, 3'd2, 32'h08,  32'hA5A55A5A, 32'h0,        2, 3, 1'b0, 32'h0,        4'b1111, 32'hA5A55A5A, 0);

    #12;
    chk_all_zero("reset");
    @(negedge clk); resetn = 1'b1; #1;

    for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // mem_ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("idle_ack%0d/resp_valid", i), 32'(resp_valid), 32'd0);
      chk($sformatf("idle_ack%0d/req_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end

    // reset in the middle of WAIT
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait/mem_addr_before", mem_addr, 32'h10);
    #2 resetn = 1'b0; #1;
    chk_all_zero("rst_wait");
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_rst%0d/resp_valid", i), 32'(resp_valid), 32'd0);
      chk($sformatf("post_rst%0d/req_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end
    run(mk(1'b1, 3'd4, 32'h01, 32'h0, 32'h0000A500, 2, 3, 1'b0, 32'h000000A5, 4'h0, 32'h0, 1),
        "lbu_after_rst", 1'b0);

    for (int i = 0; i < 150; i++) begin
      v.ld = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom();
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.ack = $urandom_range(0, 7);
      v = model(v);
      run(v, $sformatf("rnd%0d", i), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
